cpu_mmio_ctrl: RTL and testbench

- Memory/IO slave that consumes the CPU core's bus: 7-bit address, 8-bit write data, write strobe.
- Returns 8-bit read data to the CPU.
- Contains:
  - scratch RAM
  - GPIO output register
  - synchronized GPIO inputs
  - prescaled 8-bit timer with compare flag
- Sits between the CPU core and the top-level pin wrapper.

---
 rtl/cpu_mmio_pkg.sv | 24 ++
 rtl/cpu_mmio_ctrl_if.sv | 24 ++
 rtl/mmio_timer.sv | 97 +++++++++
 rtl/cpu_mmio_ctrl.sv | 94 +++++++++
 tb/tb_cpu_mmio_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_mmio_pkg.sv
// Shared constants and types for the CPU memory/IO slave: bus widths,
// register addresses and register bit positions.
package cpu_mmio_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    localparam addr_t ADDR_GPIO_OUT = 7'h40;
    localparam addr_t ADDR_GPIO_IN  = 7'h41;
    localparam addr_t ADDR_TCTRL    = 7'h42;
    localparam addr_t ADDR_TPRESC   = 7'h43;
    localparam addr_t ADDR_TCNT     = 7'h44;
    localparam addr_t ADDR_TCMP     = 7'h45;
    localparam addr_t ADDR_TSTAT    = 7'h46;

    localparam int EN_BIT    = 0;
    localparam int CLR_BIT   = 1;
    localparam int IRQ_BIT   = 2;
    localparam int MATCH_BIT = 0;

endpackage

// File: rtl/cpu_mmio_ctrl_if.sv
// CPU-side bus between the core (master) and the memory/IO slave.
interface cpu_mmio_ctrl_if;
    import cpu_mmio_pkg::*;

    addr_t address;
    data_t data_from_cpu;
    logic  write;
    data_t data_to_cpu;

    modport master (
        output address,
        output data_from_cpu,
        output write,
        input  data_to_cpu
    );

    modport slave (
        input  address,
        input  data_from_cpu,
        input  write,
        output data_to_cpu
    );

endinterface

// File: rtl/mmio_timer.sv
// Prescaled 8-bit timer with compare/match flag. Define CPU_MMIO_IRQ_EN to
// store TCTRL.IRQ_EN and drive irq = MATCH & IRQ_EN; otherwise irq is 0.
module mmio_timer
    import cpu_mmio_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  wr_tctrl,
    input  logic  wr_tpresc,
    input  logic  wr_tcnt,
    input  logic  wr_tcmp,
    input  logic  wr_tstat,
    input  data_t wdata,
    output data_t tctrl,
    output data_t tpresc,
    output data_t tcnt,
    output data_t tcmp,
    output data_t tstat,
    output logic  irq
);

    logic  en_reg, clr_reg, match_reg, match_next;
    data_t pc_reg, pc_next, tpresc_reg, tcnt_reg, tcnt_next, tcmp_reg;
    logic  tick, hit, ie_bit;

    always_comb begin
        tick       = en_reg && (pc_reg == tpresc_reg);
        hit        = (tcnt_reg == tcmp_reg);
        pc_next    = pc_reg;
        tcnt_next  = tcnt_reg;
        match_next = match_reg;

        if (wr_tpresc)
            pc_next = '0;
        else if (en_reg)
            pc_next = tick ? '0 : pc_reg + 8'd1;

        // A CPU write to TCNT overrides the tick and suppresses its compare.
        if (wr_tcnt)
            tcnt_next = wdata;
        else if (tick)
            tcnt_next = (hit && clr_reg) ? '0 : tcnt_reg + 8'd1;

        if (tick && !wr_tcnt && hit)
            match_next = 1'b1;
        else if (wr_tstat && wdata[MATCH_BIT])
            match_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_reg     <= 1'b0;
            clr_reg    <= 1'b0;
            pc_reg     <= '0;
            tpresc_reg <= '0;
            tcnt_reg   <= '0;
            tcmp_reg   <= '0;
            match_reg  <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            tcnt_reg  <= tcnt_next;
            match_reg <= match_next;
            if (wr_tctrl) begin
                en_reg  <= wdata[EN_BIT];
                clr_reg <= wdata[CLR_BIT];
            end
            if (wr_tpresc)
                tpresc_reg <= wdata;
            if (wr_tcmp)
                tcmp_reg <= wdata;
        end
    end

`ifdef CPU_MMIO_IRQ_EN
    logic ie_reg;

    always_ff @(posedge clk) begin
        if (reset)
            ie_reg <= 1'b0;
        else if (wr_tctrl)
            ie_reg <= wdata[IRQ_BIT];
    end

    assign ie_bit = ie_reg;
    assign irq    = match_reg & ie_reg;
`else
    assign ie_bit = 1'b0;
    assign irq    = 1'b0;
`endif

    assign tctrl  = {5'd0, ie_bit, clr_reg, en_reg};
    assign tpresc = tpresc_reg;
    assign tcnt   = tcnt_reg;
    assign tcmp   = tcmp_reg;
    assign tstat  = {7'd0, match_reg};

endmodule

// File: rtl/cpu_mmio_ctrl.sv
// CPU memory/IO slave: scratch RAM, GPIO out/in, and the mmio_timer block.
// irq is live only when built with CPU_MMIO_IRQ_EN.
module cpu_mmio_ctrl
    import cpu_mmio_pkg::*;
#(
    parameter int RAM_DEPTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    cpu_mmio_ctrl_if.slave  bus,
    input  data_t           gpio_in,
    output data_t           gpio_out,
    output logic            irq
);

    localparam int    RAM_AW    = $clog2(RAM_DEPTH);
    localparam addr_t RAM_LIMIT = addr_t'(RAM_DEPTH);

    data_t ram_reg [RAM_DEPTH];
    data_t sync_reg [SYNC_STAGES];
    data_t gpio_out_reg;
    data_t tctrl, tpresc, tcnt, tcmp, tstat;
    logic  ram_hit;
    logic  [RAM_AW-1:0] ram_idx;

    assign ram_hit = (bus.address < RAM_LIMIT);
    assign ram_idx = bus.address[RAM_AW-1:0];

    // RAM is flop-based: every byte must clear on reset and reads are combinational.
    genvar gi;
    generate
        for (gi = 0; gi < RAM_DEPTH; gi++) begin : g_ram
            always_ff @(posedge clk) begin
                if (reset)
                    ram_reg[gi] <= '0;
                else if (bus.write && ram_hit && (ram_idx == RAM_AW'(gi)))
                    ram_reg[gi] <= bus.data_from_cpu;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out_reg <= '0;
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_reg[i] <= '0;
        end else begin
            if (bus.write && bus.address == ADDR_GPIO_OUT)
                gpio_out_reg <= bus.data_from_cpu;
            sync_reg[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_reg[i] <= sync_reg[i-1];
        end
    end

    mmio_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .wr_tctrl  (bus.write && bus.address == ADDR_TCTRL),
        .wr_tpresc (bus.write && bus.address == ADDR_TPRESC),
        .wr_tcnt   (bus.write && bus.address == ADDR_TCNT),
        .wr_tcmp   (bus.write && bus.address == ADDR_TCMP),
        .wr_tstat  (bus.write && bus.address == ADDR_TSTAT),
        .wdata     (bus.data_from_cpu),
        .tctrl     (tctrl),
        .tpresc    (tpresc),
        .tcnt      (tcnt),
        .tcmp      (tcmp),
        .tstat     (tstat),
        .irq       (irq)
    );

    always_comb begin
        bus.data_to_cpu = '0;
        if (ram_hit) begin
            bus.data_to_cpu = ram_reg[ram_idx];
        end else begin
            case (bus.address)
                ADDR_GPIO_OUT: bus.data_to_cpu = gpio_out_reg;
                ADDR_GPIO_IN:  bus.data_to_cpu = sync_reg[SYNC_STAGES-1];
                ADDR_TCTRL:    bus.data_to_cpu = tctrl;
                ADDR_TPRESC:   bus.data_to_cpu = tpresc;
                ADDR_TCNT:     bus.data_to_cpu = tcnt;
                ADDR_TCMP:     bus.data_to_cpu = tcmp;
                ADDR_TSTAT:    bus.data_to_cpu = tstat;
                default:       bus.data_to_cpu = '0;
            endcase
        end
    end

    assign gpio_out = gpio_out_reg;

endmodule

// File: tb/tb_cpu_mmio_ctrl.sv
// Bench for cpu_mmio_ctrl: directed vector table, hand-written timer sequences,
// and random bus traffic checked every cycle against a register-map model.
module tb_cpu_mmio_ctrl;
    import cpu_mmio_pkg::*;

    localparam int RAM_DEPTH   = 16;
    localparam int SYNC_STAGES = 2;

`ifdef CPU_MMIO_IRQ_EN
    localparam bit IRQ_BUILT = 1'b1;
`else
    localparam bit IRQ_BUILT = 1'b0;
`endif

    logic  clk = 1'b0;
    logic  reset = 1'b1;
    data_t gpio_in = '0;
    data_t gpio_out;
    logic  irq;

    cpu_mmio_ctrl_if bus ();

    cpu_mmio_ctrl #(.RAM_DEPTH(RAM_DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Register-map model: one variable per architectural register.
    logic [7:0] m_ram [RAM_DEPTH];
    logic [7:0] m_gpo, m_presc, m_pc, m_tcnt, m_tcmp;
    logic       m_en, m_clr, m_ie, m_match;
    logic [7:0] m_hist [$];
    bit         m_valid = 1'b0;

    function automatic logic [7:0] m_read(logic [6:0] a);
        if (int'(a) < RAM_DEPTH) return m_ram[int'(a)];
        case (a)
            7'h40:   return m_gpo;
            7'h41:   return m_hist[0];
            7'h42:   return {5'd0, m_ie, m_clr, m_en};
            7'h43:   return m_presc;
            7'h44:   return m_tcnt;
            7'h45:   return m_tcmp;
            7'h46:   return {7'd0, m_match};
            default: return 8'h00;
        endcase
    endfunction

    task automatic m_clock(logic rst, logic w, logic [6:0] a, logic [7:0] d, logic [7:0] g);
        bit tick, hit;
        if (rst) begin
            for (int i = 0; i < RAM_DEPTH; i++) m_ram[i] = 8'h00;
            {m_gpo, m_presc, m_pc, m_tcnt, m_tcmp} = '0;
            {m_en, m_clr, m_ie, m_match} = '0;
            m_hist = {};
            for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(8'h00);
            m_valid = 1'b1;
            return;
        end
        tick = m_en && (m_pc == m_presc);
        hit  = (m_tcnt == m_tcmp);
        m_hist.push_back(g);
        void'(m_hist.pop_front());
        if (w && a == 7'h43)  m_pc = 8'h00;
        else if (m_en)        m_pc = tick ? 8'h00 : m_pc + 8'd1;
        if (tick && !(w && a == 7'h44) && hit) m_match = 1'b1;
        else if (w && a == 7'h46 && d[0])      m_match = 1'b0;
        if (w && a == 7'h44)  m_tcnt = d;
        else if (tick)        m_tcnt = (hit && m_clr) ? 8'h00 : m_tcnt + 8'd1;
        if (w) begin
            if (int'(a) < RAM_DEPTH) m_ram[int'(a)] = d;
            case (a)
                7'h40: m_gpo = d;
                7'h42: begin m_en = d[0]; m_clr = d[1]; m_ie = IRQ_BUILT ? d[2] : 1'b0; end
                7'h43: m_presc = d;
                7'h45: m_tcmp = d;
                default: ;
            endcase
        end
    endtask

    task automatic check8(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // One bus cycle: drive, compare before the edge, clock, update model.
    task automatic cyc(logic w, logic [6:0] a, logic [7:0] d, bit chk, logic [7:0] exp, string name);
        bus.write = w;
        bus.address = a;
        bus.data_from_cpu = d;
        #2;
        if (m_valid) begin
            check8({name, "/rd_model"}, bus.data_to_cpu, m_read(a));
            check8({name, "/gpio_out_model"}, gpio_out, m_gpo);
            check8({name, "/irq_model"}, {7'd0, irq}, {7'd0, m_match & m_ie & IRQ_BUILT});
        end
        if (chk) check8(name, bus.data_to_cpu, exp);
        $display("cyc t=%0t %s w=%0b a=%02h d=%02h rd=%02h gpo=%02h irq=%0b",
                 $time, name, w, a, d, bus.data_to_cpu, gpio_out, irq);
        @(posedge clk);
        m_clock(reset, w, a, d, gpio_in);
        #1;
        bus.write = 1'b0;
    endtask

    typedef struct {
        bit         w;
        logic [6:0] a;
        logic [7:0] d;
        bit         chk;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [21];

    initial begin
        logic [6:0] ra;
        logic [7:0] rd;
        bit         rw;

        tbl[0]  = '{1'b0, 7'h00, 8'h00, 1'b1, 8'h00};
        tbl[1]  = '{1'b0, 7'h40, 8'h00, 1'b1, 8'h00};
        tbl[2]  = '{1'b0, 7'h42, 8'h00, 1'b1, 8'h00};
        tbl[3]  = '{1'b0, 7'h46, 8'h00, 1'b1, 8'h00};
        tbl[4]  = '{1'b0, 7'h7F, 8'h00, 1'b1, 8'h00};
        tbl[5]  = '{1'b1, 7'h03, 8'hA5, 1'b0, 8'h00};
        tbl[6]  = '{1'b1, 7'h0F, 8'h5A, 1'b0, 8'h00};
        tbl[7]  = '{1'b0, 7'h03, 8'h00, 1'b1, 8'hA5};
        tbl[8]  = '{1'b0, 7'h0F, 8'h00, 1'b1, 8'h5A};
        tbl[9]  = '{1'b1, 7'h10, 8'hFF, 1'b0, 8'h00};
        tbl[10] = '{1'b0, 7'h10, 8'h00, 1'b1, 8'h00};
        tbl[11] = '{1'b1, 7'h40, 8'h3C, 1'b0, 8'h00};
        tbl[12] = '{1'b0, 7'h40, 8'h00, 1'b1, 8'h3C};
        tbl[13] = '{1'b1, 7'h7F, 8'h11, 1'b0, 8'h00};
        tbl[14] = '{1'b0, 7'h7F, 8'h00, 1'b1, 8'h00};
        tbl[15] = '{1'b1, 7'h3F, 8'h77, 1'b0, 8'h00};
        tbl[16] = '{1'b0, 7'h3F, 8'h00, 1'b1, 8'h00};
        tbl[17] = '{1'b1, 7'h47, 8'h33, 1'b0, 8'h00};
        tbl[18] = '{1'b0, 7'h47, 8'h00, 1'b1, 8'h00};
        tbl[19] = '{1'b1, 7'h41, 8'hFF, 1'b0, 8'h00};
        tbl[20] = '{1'b0, 7'h41, 8'h00, 1'b1, 8'h00};

        bus.write = 1'b0;
        bus.address = '0;
        bus.data_from_cpu = '0;
        #1;
        repeat (3) cyc(1'b0, 7'h00, 8'h00, 1'b0, 8'h00, "reset");
        reset = 1'b0;
        check8("rst_gpio_out", gpio_out, 8'h00);
        check8("rst_irq", {7'd0, irq}, 8'h00);

        for (int i = 0; i < 21; i++)
            cyc(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].chk, tbl[i].exp, $sformatf("vec%0d", i));
        check8("gpio_out_3c", gpio_out, 8'h3C);

        // GPIO input synchroniser latency.
        gpio_in = 8'h96;
        cyc(1'b0, 7'h41, 8'h00, 1'b1, 8'h00, "gpin_sample");
        for (int k = 0; k < SYNC_STAGES - 1; k++)
            cyc(1'b0, 7'h41, 8'h00, 1'b1, 8'h00, "gpin_old");
        cyc(1'b0, 7'h41, 8'h00, 1'b1, 8'h96, "gpin_new");

        // Prescaled count with clear-on-match.
        cyc(1'b1, 7'h43, 8'h02, 1'b0, 8'h00, "w_presc");
        cyc(1'b1, 7'h45, 8'h03, 1'b0, 8'h00, "w_tcmp");
        cyc(1'b1, 7'h42, 8'h03, 1'b0, 8'h00, "w_tctrl");
        for (int i = 1; i <= 13; i++)
            cyc(1'b0, 7'h44, 8'h00, 1'b1, (i <= 12) ? 8'((i - 1) / 3) : 8'h00,
                $sformatf("tcnt_seq%0d", i));
        cyc(1'b0, 7'h46, 8'h00, 1'b1, 8'h01, "match_set");
        cyc(1'b1, 7'h46, 8'h01, 1'b0, 8'h00, "w1c");
        cyc(1'b0, 7'h46, 8'h00, 1'b1, 8'h00, "match_clr");
        cyc(1'b1, 7'h42, 8'h00, 1'b0, 8'h00, "stop");

        // Wrap at 0xFF with a tick every cycle.
        cyc(1'b1, 7'h43, 8'h00, 1'b0, 8'h00, "w_presc0");
        cyc(1'b1, 7'h45, 8'h10, 1'b0, 8'h00, "w_tcmp10");
        cyc(1'b1, 7'h44, 8'hFE, 1'b0, 8'h00, "w_tcntfe");
        cyc(1'b1, 7'h42, 8'h01, 1'b0, 8'h00, "w_en");
        cyc(1'b0, 7'h44, 8'h00, 1'b1, 8'hFE, "wrap_fe");
        cyc(1'b0, 7'h44, 8'h00, 1'b1, 8'hFF, "wrap_ff");
        cyc(1'b0, 7'h44, 8'h00, 1'b1, 8'h00, "wrap_00");
        cyc(1'b0, 7'h44, 8'h00, 1'b1, 8'h01, "wrap_01");

        // CPU write to TCNT on a tick cycle wins.
        cyc(1'b1, 7'h44, 8'h50, 1'b0, 8'h00, "tcnt_coll");
        cyc(1'b0, 7'h44, 8'h00, 1'b1, 8'h50, "tcnt_cpu_wins");

        // MATCH set on the same edge as a W1C: set wins.
        cyc(1'b1, 7'h42, 8'h00, 1'b0, 8'h00, "stop2");
        cyc(1'b1, 7'h44, 8'h20, 1'b0, 8'h00, "w_tcnt20");
        cyc(1'b1, 7'h45, 8'h20, 1'b0, 8'h00, "w_tcmp20");
        cyc(1'b1, 7'h43, 8'h00, 1'b0, 8'h00, "w_presc0b");
        cyc(1'b0, 7'h46, 8'h00, 1'b1, 8'h00, "match_pre");
        cyc(1'b1, 7'h42, 8'h01, 1'b0, 8'h00, "w_en2");
        cyc(1'b1, 7'h46, 8'h01, 1'b0, 8'h00, "w1c_coll");
        cyc(1'b0, 7'h46, 8'h00, 1'b1, 8'h01, "set_wins");

        // Interrupt gating with MATCH already set.
        cyc(1'b1, 7'h42, 8'h05, 1'b0, 8'h00, "w_tctrl05");
        check8("irq_on", {7'd0, irq}, {7'd0, IRQ_BUILT});
        cyc(1'b0, 7'h42, 8'h00, 1'b1, IRQ_BUILT ? 8'h05 : 8'h01, "tctrl_rd");
        cyc(1'b1, 7'h42, 8'h01, 1'b0, 8'h00, "w_tctrl01");
        check8("irq_off", {7'd0, irq}, 8'h00);
        cyc(1'b0, 7'h46, 8'h00, 1'b1, 8'h01, "match_kept");
        cyc(1'b1, 7'h42, 8'h00, 1'b0, 8'h00, "stop3");

        // Random traffic against the model, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0) gpio_in = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       ra = 7'($urandom);
                1:       ra = 7'h40 + 7'($urandom_range(0, 6));
                2:       ra = 7'($urandom_range(0, RAM_DEPTH - 1));
                default: ra = 7'h44;
            endcase
            rw = ($urandom_range(0, 2) == 0);
            rd = 8'($urandom);
            if (ra == 7'h43 && rw) rd = 8'($urandom_range(0, 3));
            cyc(rw, ra, rd, 1'b0, 8'h00, "rand");
        end
        reset = 1'b0;
        cyc(1'b0, 7'h44, 8'h00, 1'b0, 8'h00, "final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
